// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller: IR key codes, FSM states, screen codes.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
package snake_pkg;

  // NEC words as delivered by irReceiver for the remote keys in use.
  localparam logic [31:0] KEY_UP    = 32'h00FF18E7;
  localparam logic [31:0] KEY_DOWN  = 32'h00FF4AB5;
  localparam logic [31:0] KEY_LEFT  = 32'h00FF10EF;
  localparam logic [31:0] KEY_RIGHT = 32'h00FF5AA5;
  localparam logic [31:0] KEY_ENTER = 32'h00FF38C7;
  localparam logic [31:0] KEY_MENU  = 32'h00FFA25D;
  localparam logic [31:0] KEY_ONE   = 32'h00FF8877;
  localparam logic [31:0] KEY_TWO   = 32'h00FF48B7;
  localparam logic [31:0] KEY_THREE = 32'h00FFC837;
  localparam logic [31:0] KEY_FOUR  = 32'h00FF28D7;
  localparam logic [31:0] KEY_FIVE  = 32'h00FFA857;
  localparam logic [31:0] KEY_SIX   = 32'h00FF6897;

  // Controller states.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_END   = 2'd3
  } state_e;

  // screen_sel encoding.
  localparam logic [1:0] SCR_START = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_END   = 2'd2;

  localparam logic [2:0] DIFF_RESET = 3'd4;

  // Tick period in clock cycles for a given level; evaluated at elaboration only.
  function automatic int unsigned tick_period(input int unsigned clk_freq,
                                              input int unsigned step,
                                              input int unsigned level);
    return clk_freq / (step * level);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Snake step tick generator: counts PLAY cycles and pulses once per period of the current level.
// Latency: tick_o is registered, high the cycle after the counter sat at its last value.
// Backpressure: none; hold_i freezes the count, clr_i zeroes it, kill_i suppresses a pending tick.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           count this cycle (controller in PLAY)
//   hold_i         keep the current count (controller in PAUSE)
//   clr_i          zero the count (controller in START or END)
//   kill_i         controller leaves PLAY at this edge: no tick may follow
//   level_i        difficulty 1..6, selects the period
//   tick_o         one-cycle step pulse
module tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_STEP = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       hold_i,
  input  logic       clr_i,
  input  logic       kill_i,
  input  logic [2:0] level_i,
  output logic       tick_o
);

  localparam int unsigned P1    = tick_period(CLK_FREQ, TICK_STEP, 1);
  localparam int unsigned CNT_W = (P1 > 1) ? $clog2(P1) : 1;

  // Last counter value for each level (period minus one).
  localparam logic [CNT_W-1:0] PER_M1 [1:6] = '{
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 1) - 1),
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 2) - 1),
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 3) - 1),
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 4) - 1),
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 5) - 1),
    CNT_W'(tick_period(CLK_FREQ, TICK_STEP, 6) - 1)
  };

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    last_cnt = PER_M1[4];
    case (level_i)
      3'd1:    last_cnt = PER_M1[1];
      3'd2:    last_cnt = PER_M1[2];
      3'd3:    last_cnt = PER_M1[3];
      3'd4:    last_cnt = PER_M1[4];
      3'd5:    last_cnt = PER_M1[5];
      3'd6:    last_cnt = PER_M1[6];
      default: last_cnt = PER_M1[4];
    endcase
  end

  assign wrap = (cnt_q == last_cnt);

  // The counter still advances (and may wrap) in the cycle that leaves PLAY;
  // only the tick for that wrap is dropped.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap && !kill_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Snake game controller: IR-key driven START/PLAY/PAUSE/END screens, difficulty and step ticks.
// Latency: every output is registered and reflects the command sampled at the previous edge.
// Backpressure: none; a command exists only in a cycle with ir_valid=1 and is never queued.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   ir_word        last decoded NEC word, ir_valid one-cycle strobe for a new word
//   game_over      collision level from snakegame
//   game_enable    high in PLAY and PAUSE
//   game_tick      one-cycle snake step pulse (PLAY only)
//   game_restart   one-cycle pulse in the first PLAY cycle after START
//   difficulty     level 1..6
//   screen_sel     0 start grid, 1 game grid, 2 end grid
module game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_STEP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir_word,
  input  logic        ir_valid,
  input  logic        game_over,
  output logic        game_enable,
  output logic        game_tick,
  output logic        game_restart,
  output logic [2:0]  difficulty,
  output logic [1:0]  screen_sel
);

  state_e      state_q, state_d;
  logic [2:0]  diff_q, diff_d;
  logic        enable_q, enable_d;
  logic        restart_q, restart_d;
  logic [1:0]  screen_q, screen_d;

  logic        key_enter, key_menu, key_lvl;
  logic [2:0]  lvl;

  // Key decode. ONE is recognised on its low half only; remotes differ in the
  // upper address bytes for that key.
  always_comb begin
    key_enter = ir_valid && (ir_word == KEY_ENTER);
    key_menu  = ir_valid && (ir_word == KEY_MENU);
    key_lvl   = 1'b0;
    lvl       = diff_q;
    if (ir_valid) begin
      if (ir_word[15:0] == KEY_ONE[15:0]) begin
        key_lvl = 1'b1;
        lvl     = 3'd1;
      end else if (ir_word == KEY_TWO) begin
        key_lvl = 1'b1;
        lvl     = 3'd2;
      end else if (ir_word == KEY_THREE) begin
        key_lvl = 1'b1;
        lvl     = 3'd3;
      end else if (ir_word == KEY_FOUR) begin
        key_lvl = 1'b1;
        lvl     = 3'd4;
      end else if (ir_word == KEY_FIVE) begin
        key_lvl = 1'b1;
        lvl     = 3'd5;
      end else if (ir_word == KEY_SIX) begin
        key_lvl = 1'b1;
        lvl     = 3'd6;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    case (state_q)
      ST_START: begin
        if (key_enter)    state_d = ST_PLAY;
        else if (key_lvl) diff_d  = lvl;
      end
      ST_PLAY: begin
        // Collision wins over a simultaneous pause request.
        if (game_over)      state_d = ST_END;
        else if (key_enter) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (key_enter)     state_d = ST_PLAY;
        else if (key_menu) state_d = ST_START;
      end
      ST_END: begin
        if (key_menu) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase

    enable_d  = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
    // Only a fresh game restarts snakegame; resuming from PAUSE does not.
    restart_d = (state_q == ST_START) && (state_d == ST_PLAY);

    case (state_d)
      ST_START: screen_d = SCR_START;
      ST_END:   screen_d = SCR_END;
      default:  screen_d = SCR_GAME;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_START;
      diff_q    <= DIFF_RESET;
      enable_q  <= 1'b0;
      restart_q <= 1'b0;
      screen_q  <= SCR_START;
    end else begin
      state_q   <= state_d;
      diff_q    <= diff_d;
      enable_q  <= enable_d;
      restart_q <= restart_d;
      screen_q  <= screen_d;
    end
  end

  logic tg_en, tg_hold, tg_clr, tg_kill;

  assign tg_en   = (state_q == ST_PLAY);
  assign tg_hold = (state_q == ST_PAUSE);
  assign tg_clr  = (state_q == ST_START) || (state_q == ST_END);
  assign tg_kill = (state_d != ST_PLAY);

  tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_STEP (TICK_STEP)
  ) u_tick_gen (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .en_i    (tg_en),
    .hold_i  (tg_hold),
    .clr_i   (tg_clr),
    .kill_i  (tg_kill),
    .level_i (diff_q),
    .tick_o  (game_tick)
  );

  assign game_enable  = enable_q;
  assign game_restart = restart_q;
  assign difficulty   = diff_q;
  assign screen_sel   = screen_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl at CLK_FREQ=1200, TICK_STEP=2 (periods 600..100 cycles).
module tb_game_ctrl;
  import snake_pkg::*;

  localparam int CF = 1200;
  localparam int TS = 2;

  logic        clk;
  logic        reset_n;
  logic [31:0] ir_word;
  logic        ir_valid;
  logic        game_over;
  logic        game_enable;
  logic        game_tick;
  logic        game_restart;
  logic [2:0]  difficulty;
  logic [1:0]  screen_sel;

  game_ctrl #(.CLK_FREQ(CF), .TICK_STEP(TS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_word      (ir_word),
    .ir_valid     (ir_valid),
    .game_over    (game_over),
    .game_enable  (game_enable),
    .game_tick    (game_tick),
    .game_restart (game_restart),
    .difficulty   (difficulty),
    .screen_sel   (screen_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int rst_seen = 0;

  // Behavioural reference: mode by name, difficulty, and PLAY cycles elapsed
  // within the current period.
  string      m_mode;
  int         m_diff;
  int         m_phase;
  logic       e_en, e_tick, e_rst;
  logic [1:0] e_scr;
  logic [2:0] e_diff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_per(input int d);
    return CF / (TS * d);
  endfunction

  task automatic model_reset();
    m_mode = "START"; m_diff = 4; m_phase = 0;
    e_en = 1'b0; e_tick = 1'b0; e_rst = 1'b0; e_scr = 2'd0; e_diff = 3'd4;
  endtask

  task automatic model_step(input logic vld, input logic [31:0] w, input logic go);
    string nxt;
    int    lv;
    bit    k_ent, k_menu, wrapped;
    k_ent  = vld && (w == KEY_ENTER);
    k_menu = vld && (w == KEY_MENU);
    lv = 0;
    if (vld) begin
      if (w[15:0] == 16'h8877) lv = 1;
      else if (w == KEY_TWO)   lv = 2;
      else if (w == KEY_THREE) lv = 3;
      else if (w == KEY_FOUR)  lv = 4;
      else if (w == KEY_FIVE)  lv = 5;
      else if (w == KEY_SIX)   lv = 6;
    end
    nxt = m_mode;
    if (m_mode == "START") begin
      if (k_ent) nxt = "PLAY";
      else if (lv != 0) m_diff = lv;
    end else if (m_mode == "PLAY") begin
      if (go) nxt = "END";
      else if (k_ent) nxt = "PAUSE";
    end else if (m_mode == "PAUSE") begin
      if (k_ent) nxt = "PLAY";
      else if (k_menu) nxt = "START";
    end else begin
      if (k_menu) nxt = "START";
    end
    wrapped = 1'b0;
    if (m_mode == "PLAY") begin
      m_phase++;
      if (m_phase == model_per(m_diff)) begin
        m_phase = 0;
        wrapped = 1'b1;
      end
    end else if (m_mode != "PAUSE") begin
      m_phase = 0;
    end
    e_tick = (m_mode == "PLAY") && (nxt == "PLAY") && wrapped;
    e_rst  = (m_mode == "START") && (nxt == "PLAY");
    m_mode = nxt;
    e_en   = (nxt == "PLAY") || (nxt == "PAUSE");
    e_scr  = (nxt == "START") ? 2'd0 : (nxt == "END") ? 2'd2 : 2'd1;
    e_diff = 3'(m_diff);
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare #1 later.
  task automatic cycle(input logic vld, input logic [31:0] w, input logic go);
    ir_valid  = vld;
    ir_word   = w;
    game_over = go;
    @(posedge clk);
    model_step(vld, w, go);
    #1;
    chk("m_enable",  32'(game_enable),  32'(e_en));
    chk("m_tick",    32'(game_tick),    32'(e_tick));
    chk("m_restart", 32'(game_restart), 32'(e_rst));
    chk("m_screen",  32'(screen_sel),   32'(e_scr));
    chk("m_diff",    32'(difficulty),   32'(e_diff));
    chk("tick_restart_excl", 32'(game_tick & game_restart), 32'd0);
    if (game_restart) rst_seen++;
    ir_valid = 1'b0;
  endtask

  // Cycles until game_tick, counted from the next clock; -1 if the budget runs out.
  task automatic wait_tick(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget && lat < 0; n++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (game_tick) lat = n;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable"},  32'(game_enable),  32'd0);
    chk({tag, "_tick"},    32'(game_tick),    32'd0);
    chk({tag, "_restart"}, 32'(game_restart), 32'd0);
    chk({tag, "_screen"},  32'(screen_sel),   32'd0);
    chk({tag, "_diff"},    32'(difficulty),   32'd4);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] word;
    int          reps;
    logic [2:0]  ediff;
    logic [1:0]  escr;
    logic        een;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, ticks, rst_before;
    logic        vld, go;
    logic [31:0] w, tmp;

    vecs[0] = '{1'b1, KEY_THREE,    51, 3'd3, 2'd0, 1'b0};  // strobe once, then held 50 cycles
    vecs[1] = '{1'b1, 32'h00008877,  1, 3'd1, 2'd0, 1'b0};  // ONE by low half
    vecs[2] = '{1'b1, KEY_TWO,       1, 3'd2, 2'd0, 1'b0};
    vecs[3] = '{1'b1, 32'h12348877,  1, 3'd1, 2'd0, 1'b0};  // ONE, upper half ignored
    vecs[4] = '{1'b1, KEY_UP,        3, 3'd1, 2'd0, 1'b0};  // non-level key ignored
    vecs[5] = '{1'b1, 32'h01FFA857,  1, 3'd1, 2'd0, 1'b0};  // FIVE with one bit off
    vecs[6] = '{1'b1, KEY_SIX,       1, 3'd6, 2'd0, 1'b0};
    vecs[7] = '{1'b0, KEY_ENTER,     5, 3'd6, 2'd0, 1'b0};  // ENTER without strobe
    vecs[8] = '{1'b1, KEY_MENU,      2, 3'd6, 2'd0, 1'b0};  // MENU ignored in START

    reset_n = 1'b1; ir_valid = 1'b0; ir_word = 32'h0; game_over = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst");
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // START: difficulty keys and ignored words.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].vld, vecs[i].word, 1'b0);
      for (int k = 1; k < vecs[i].reps; k++) cycle(1'b0, vecs[i].word, 1'b0);
      chk($sformatf("vec%0d_diff", i),   32'(difficulty),  32'(vecs[i].ediff));
      chk($sformatf("vec%0d_screen", i), 32'(screen_sel),  32'(vecs[i].escr));
      chk($sformatf("vec%0d_enable", i), 32'(game_enable), 32'(vecs[i].een));
    end

    // Level 6: restart in first PLAY cycle, tick 100 cycles after entry, then every 100.
    cycle(1'b1, KEY_ENTER, 1'b0);
    chk("play6_restart", 32'(game_restart), 32'd1);
    chk("play6_enable",  32'(game_enable),  32'd1);
    chk("play6_screen",  32'(screen_sel),   32'd1);
    wait_tick(300, lat);
    chk("play6_first_tick", 32'(lat), 32'd100);
    wait_tick(300, lat);
    chk("play6_second_tick", 32'(lat), 32'd100);
    chk("play6_restart_once", 32'(rst_seen), 32'd1);

    // Level key in PLAY ignored (PLAY index 201 after this).
    cycle(1'b1, KEY_FIVE, 1'b0);
    chk("play_five_ignored", 32'(difficulty), 32'd6);

    // game_over and ENTER together exactly when the counter wraps: END, no tick.
    for (int k = 0; k < 98; k++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, KEY_ENTER, 1'b1);
    chk("end_screen", 32'(screen_sel),  32'd2);
    chk("end_enable", 32'(game_enable), 32'd0);
    chk("end_tick",   32'(game_tick),   32'd0);
    cycle(1'b1, KEY_FIVE, 1'b1);
    cycle(1'b1, KEY_ENTER, 1'b1);
    chk("end_five_ignored", 32'(difficulty), 32'd6);
    chk("end_enter_ignored", 32'(screen_sel), 32'd2);
    cycle(1'b1, KEY_MENU, 1'b0);
    chk("menu_screen", 32'(screen_sel), 32'd0);

    // Level 4 (P=150): pause at counter 70, hold 500 cycles, resume.
    cycle(1'b1, KEY_FOUR, 1'b0);
    chk("lvl4_diff", 32'(difficulty), 32'd4);
    cycle(1'b1, KEY_ENTER, 1'b0);
    for (int k = 0; k < 70; k++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, KEY_ENTER, 1'b0);
    chk("pause_enable", 32'(game_enable), 32'd1);
    chk("pause_screen", 32'(screen_sel),  32'd1);
    ticks = 0;
    for (int k = 0; k < 500; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (game_tick) ticks++;
    end
    chk("pause_no_ticks", 32'(ticks), 32'd0);
    rst_before = rst_seen;
    cycle(1'b1, KEY_ENTER, 1'b0);
    wait_tick(200, lat);
    chk("resume_latency", 32'(lat + 1), 32'd80);
    chk("resume_no_restart", 32'(rst_seen), 32'(rst_before));

    // Asynchronous reset mid-PLAY.
    cycle(1'b1, KEY_ENTER, 1'b0);
    cycle(1'b1, KEY_MENU, 1'b0);
    cycle(1'b1, KEY_TWO, 1'b0);
    chk("lvl2_diff", 32'(difficulty), 32'd2);
    cycle(1'b1, KEY_ENTER, 1'b0);
    for (int k = 0; k < 30; k++) cycle(1'b0, 32'h0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("arst");
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 20; k++) cycle(1'b0, 32'h0, 1'b0);
    chk("arst_wait_screen", 32'(screen_sel),  32'd0);
    chk("arst_wait_enable", 32'(game_enable), 32'd0);
    cycle(1'b1, KEY_ENTER, 1'b0);
    chk("arst_enter_restart", 32'(game_restart), 32'd1);

    // Random traffic against the reference.
    go = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      vld = ($urandom_range(0, 15) < 3);
      tmp = $urandom();
      case ($urandom_range(0, 11))
        0:  w = ($urandom_range(0, 3) == 0) ? KEY_ENTER : KEY_UP;
        1:  w = KEY_MENU;
        2:  w = KEY_ONE;
        3:  w = KEY_TWO;
        4:  w = KEY_THREE;
        5:  w = KEY_FOUR;
        6:  w = KEY_FIVE;
        7:  w = KEY_SIX;
        8:  w = KEY_DOWN;
        9:  w = {tmp[31:16], 16'h8877};
        10: w = KEY_LEFT;
        default: w = tmp;
      endcase
      if (!go && $urandom_range(0, 799) == 0) go = 1'b1;
      else if (go && $urandom_range(0, 7) == 0) go = 1'b0;
      cycle(vld, w, go);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
